// File: rtl/dmac_read_scheduler.sv
// dmac_read_scheduler: round-robin multi-channel read scheduler splitting transfers into AXI INCR bursts.
// Optional feature macro DMAC_RD_4K_BOUNDARY_EN: when defined, no burst crosses a 4 KB boundary.
module dmac_read_scheduler #(
  parameter int ADDR_WD = 32,
  parameter int DATA_WD = 32,
  parameter int CHANNEL_COUNT = 8,
  parameter int MAX_BURST_LEN = 16,
  parameter int BEATS_WD = 16,
  localparam int CH_WD = $clog2(CHANNEL_COUNT)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [CHANNEL_COUNT-1:0]          ch_cmd_valid,
  output logic [CHANNEL_COUNT-1:0]          ch_cmd_ready,
  input  logic [CHANNEL_COUNT*ADDR_WD-1:0]  ch_cmd_addr,
  input  logic [CHANNEL_COUNT*BEATS_WD-1:0] ch_cmd_beats,
  output logic [CHANNEL_COUNT-1:0]          ch_done,
  output logic                              rd_req_valid,
  input  logic                              rd_req_ready,
  output logic [ADDR_WD-1:0]                rd_req_addr,
  output logic [1:0]                        rd_req_burst,
  output logic [7:0]                        rd_req_len,
  output logic [2:0]                        rd_req_size,
  output logic [CH_WD-1:0]                  rd_req_chan
);
  localparam int STRB_WD = DATA_WD / 8;
  localparam int SZ = $clog2(STRB_WD);
  typedef enum logic {ARB, ISSUE} state_t;
  state_t state;
  logic [CHANNEL_COUNT-1:0] active;
  logic [ADDR_WD-1:0] cur_addr [CHANNEL_COUNT];
  logic [BEATS_WD-1:0] remaining [CHANNEL_COUNT];
  logic [CH_WD-1:0] rr_ptr, grant, cand;
  logic found;
  logic [31:0] lim, cap;
  logic [7:0] len;
`ifdef DMAC_RD_4K_BOUNDARY_EN
  logic [31:0] to_4k;
`endif
  assign ch_cmd_ready = ~active;
  assign rd_req_burst = 2'b01;
  assign rd_req_size = 3'(SZ);
  // Pick the first active channel at or after the round-robin pointer and size its next burst.
  always_comb begin
    found = 1'b0;
    grant = '0;
    cand = '0;
    for (int k = 0; k < CHANNEL_COUNT; k++) begin
      cand = CH_WD'((int'(rr_ptr) + k) % CHANNEL_COUNT);
      if (!found && active[cand]) begin
        found = 1'b1;
        grant = cand;
      end
    end
    lim = 32'(remaining[grant]) < 32'(MAX_BURST_LEN) ? 32'(remaining[grant]) : 32'(MAX_BURST_LEN);
`ifdef DMAC_RD_4K_BOUNDARY_EN
    to_4k = (32'd4096 - {20'd0, cur_addr[grant][11:0]}) >> SZ;
    cap = to_4k < lim ? to_4k : lim;
`else
    cap = lim;
`endif
    len = 8'(cap - 32'd1);
  end
  // Channel bookkeeping plus the ARB/ISSUE FSM with registered request outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ARB;
      active <= '0;
      rr_ptr <= '0;
      ch_done <= '0;
      rd_req_valid <= 1'b0;
      rd_req_addr <= '0;
      rd_req_len <= '0;
      rd_req_chan <= '0;
      for (int i = 0; i < CHANNEL_COUNT; i++) begin
        cur_addr[i] <= '0;
        remaining[i] <= '0;
      end
    end else begin
      ch_done <= '0;
      for (int i = 0; i < CHANNEL_COUNT; i++) begin
        if (ch_cmd_valid[i] && !active[i]) begin
          if (ch_cmd_beats[i*BEATS_WD +: BEATS_WD] == '0) begin
            ch_done[i] <= 1'b1;
          end else begin
            active[i] <= 1'b1;
            cur_addr[i] <= ch_cmd_addr[i*ADDR_WD +: ADDR_WD] & ~ADDR_WD'(STRB_WD - 1);
            remaining[i] <= ch_cmd_beats[i*BEATS_WD +: BEATS_WD];
          end
        end
      end
      if (state == ARB) begin
        if (found) begin
          state <= ISSUE;
          rd_req_valid <= 1'b1;
          rd_req_addr <= cur_addr[grant];
          rd_req_len <= len;
          rd_req_chan <= grant;
        end
      end else if (rd_req_ready) begin
        state <= ARB;
        rd_req_valid <= 1'b0;
        cur_addr[rd_req_chan] <= cur_addr[rd_req_chan] + ADDR_WD'((32'(rd_req_len) + 32'd1) * STRB_WD);
        remaining[rd_req_chan] <= remaining[rd_req_chan] - BEATS_WD'(32'(rd_req_len) + 32'd1);
        rr_ptr <= CH_WD'((int'(rd_req_chan) + 1) % CHANNEL_COUNT);
        if (32'(remaining[rd_req_chan]) == 32'(rd_req_len) + 32'd1) begin
          active[rd_req_chan] <= 1'b0;
          ch_done[rd_req_chan] <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_dmac_read_scheduler.sv
// tb_dmac_read_scheduler: directed bench for the DMA read-request scheduler.
module tb_dmac_read_scheduler;
  localparam int N = 8;
  localparam int AW = 32;
  localparam int BW = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] ch_cmd_valid = '0;
  logic [N-1:0] ch_cmd_ready;
  logic [N*AW-1:0] ch_cmd_addr = '0;
  logic [N*BW-1:0] ch_cmd_beats = '0;
  logic [N-1:0] ch_done;
  logic rd_req_valid;
  logic rd_req_ready = 1'b1;
  logic [AW-1:0] rd_req_addr;
  logic [1:0] rd_req_burst;
  logic [7:0] rd_req_len;
  logic [2:0] rd_req_size;
  logic [2:0] rd_req_chan;
  int nvec = 0;
  int nerr = 0;

  dmac_read_scheduler dut (
    .clk(clk), .rst(rst),
    .ch_cmd_valid(ch_cmd_valid), .ch_cmd_ready(ch_cmd_ready),
    .ch_cmd_addr(ch_cmd_addr), .ch_cmd_beats(ch_cmd_beats),
    .ch_done(ch_done),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
    .rd_req_addr(rd_req_addr), .rd_req_burst(rd_req_burst),
    .rd_req_len(rd_req_len), .rd_req_size(rd_req_size), .rd_req_chan(rd_req_chan)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cmd(input int ch, input logic [AW-1:0] addr, input logic [BW-1:0] beats);
    ch_cmd_valid = '0;
    ch_cmd_valid[ch] = 1'b1;
    ch_cmd_addr[ch*AW +: AW] = addr;
    ch_cmd_beats[ch*BW +: BW] = beats;
    @(negedge clk);
    ch_cmd_valid = '0;
  endtask

  task automatic wait_req();
    for (int k = 0; k < 20 && !rd_req_valid; k++) @(negedge clk);
    chk("req_valid_timeout", rd_req_valid, 1);
  endtask

  task automatic burst(input string tag, input logic [AW-1:0] addr, input logic [7:0] len,
                       input logic [2:0] chan, input logic [N-1:0] done);
    wait_req();
    chk({tag, "_addr"}, rd_req_addr, addr);
    chk({tag, "_len"}, rd_req_len, len);
    chk({tag, "_chan"}, rd_req_chan, chan);
    @(negedge clk);
    chk({tag, "_done"}, ch_done, done);
    chk({tag, "_valid_drop"}, rd_req_valid, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_valid", rd_req_valid, 0);
    chk("rst_addr", rd_req_addr, 0);
    chk("rst_len", rd_req_len, 0);
    chk("rst_chan", rd_req_chan, 0);
    chk("rst_done", ch_done, 0);
    chk("rst_ready", ch_cmd_ready, 8'hFF);
    chk("burst_type", rd_req_burst, 2'b01);
    chk("size", rd_req_size, 3'd2);
    // 40 beats from 0x1000: 16 + 16 + 8
    cmd(0, 32'h1000, 16'd40);
    chk("t1_busy", ch_cmd_ready[0], 0);
    chk("t1_lat_lo", rd_req_valid, 0);
    @(negedge clk);
    chk("t1_lat_hi", rd_req_valid, 1);
    burst("t1b0", 32'h1000, 8'd15, 3'd0, 8'h00);
    burst("t1b1", 32'h1040, 8'd15, 3'd0, 8'h00);
    burst("t1b2", 32'h1080, 8'd7, 3'd0, 8'h01);
    chk("t1_idle", ch_cmd_ready[0], 1);
    @(negedge clk);
    chk("t1_done_once", ch_done, 0);
    // 4 KB boundary behaviour
    cmd(1, 32'h0FF0, 16'd8);
`ifdef DMAC_RD_4K_BOUNDARY_EN
    burst("t2b0", 32'h0FF0, 8'd3, 3'd1, 8'h00);
    burst("t2b1", 32'h1000, 8'd3, 3'd1, 8'h02);
`else
    burst("t2b0", 32'h0FF0, 8'd7, 3'd1, 8'h02);
`endif
    // Reset returns the round-robin pointer to channel 0
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ch_cmd_valid = 8'h05;
    ch_cmd_addr[0 +: AW] = 32'h2000;
    ch_cmd_addr[2*AW +: AW] = 32'h3000;
    ch_cmd_beats[0 +: BW] = 16'd32;
    ch_cmd_beats[2*BW +: BW] = 16'd32;
    @(negedge clk);
    ch_cmd_valid = '0;
    burst("t3b0", 32'h2000, 8'd15, 3'd0, 8'h00);
    burst("t3b1", 32'h3000, 8'd15, 3'd2, 8'h00);
    burst("t3b2", 32'h2040, 8'd15, 3'd0, 8'h01);
    burst("t3b3", 32'h3040, 8'd15, 3'd2, 8'h04);
    // Back-pressure: request must hold steady while ready is low
    rd_req_ready = 1'b0;
    cmd(5, 32'h4003, 16'd4);
    wait_req();
    for (int k = 0; k < 5; k++) begin
      chk("t4_hold_valid", rd_req_valid, 1);
      chk("t4_hold_addr", rd_req_addr, 32'h4000);
      chk("t4_hold_len", rd_req_len, 8'd3);
      chk("t4_hold_chan", rd_req_chan, 3'd5);
      if (k == 4) rd_req_ready = 1'b1;
      @(negedge clk);
    end
    chk("t4_done", ch_done, 8'h20);
    chk("t4_valid_drop", rd_req_valid, 0);
    // Zero-beat command
    cmd(3, 32'h5000, 16'd0);
    chk("t5_done", ch_done, 8'h08);
    chk("t5_idle", ch_cmd_ready[3], 1);
    chk("t5_no_req", rd_req_valid, 0);
    @(negedge clk);
    chk("t5_done_clear", ch_done, 0);
    chk("t5_no_req2", rd_req_valid, 0);
    // Reset while a request is pending
    rd_req_ready = 1'b0;
    cmd(6, 32'h5000, 16'd40);
    wait_req();
    #2 rst = 1'b1;
    #1;
    chk("t6_valid", rd_req_valid, 0);
    chk("t6_addr", rd_req_addr, 0);
    chk("t6_len", rd_req_len, 0);
    chk("t6_chan", rd_req_chan, 0);
    chk("t6_ready", ch_cmd_ready, 8'hFF);
    @(negedge clk);
    rst = 1'b0;
    rd_req_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t6_no_done", ch_done, 0);
      chk("t6_no_req", rd_req_valid, 0);
    end
    cmd(6, 32'h6000, 16'd4);
    burst("t6b0", 32'h6000, 8'd3, 3'd6, 8'h40);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
